// File: rtl/totp_host_driver_if.sv
// Bundle of the host-facing request/result signals and the serial pins
// toward the TOTP core for totp_host_driver.
// Latency: none (wires only).
// Backpressure: none; the driver paces itself on busy and the core's ready.
// Ports (as signals): start/key/msg in, busy/done/error/code result out,
// data/key_en/msg_en/sel toward the core, ready/bcd back from the core.
interface totp_host_driver_if #(
  parameter int KEY_BITS = 160,
  parameter int MSG_BITS = 64,
  parameter int DIGITS   = 6
);
  // host side
  logic                  start;
  logic [KEY_BITS-1:0]   key;
  logic [MSG_BITS-1:0]   msg;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [4*DIGITS-1:0]   code;
  // core side
  logic                  data;
  logic                  key_en;
  logic                  msg_en;
  logic [2:0]            sel;
  logic                  ready;
  logic [3:0]            bcd;

  // master: the driver itself
  modport master (
    input  start, key, msg, ready, bcd,
    output busy, done, error, code, data, key_en, msg_en, sel
  );

  // slave: the host and core that surround the driver
  modport slave (
    output start, key, msg, ready, bcd,
    input  busy, done, error, code, data, key_en, msg_en, sel
  );
endinterface

// File: rtl/totp_host_driver.sv
// Host-side initiator for the TOTP core: shifts key then message out MSB
// first, waits for ready, walks sel over every digit and returns the code.
// Latency: done lands KEY_BITS+MSG_BITS+2 + ready wait + DIGITS*(SETTLE+1)+1
// cycles after the accepting edge. Backpressure: start is ignored while busy.
// Ports: clk, rst (sync, active-high) plus the bus interface (master side):
// start/key/msg in, busy/done/error/code out, data/key_en/msg_en/sel to the
// core, ready/bcd from the core. Every output comes straight from a flop.
module totp_host_driver #(
  parameter int KEY_BITS = 160,
  parameter int MSG_BITS = 64,
  parameter int DIGITS   = 6,
  parameter int SETTLE   = 2,
  parameter int TIMEOUT  = 65535
) (
  input  logic              clk,
  input  logic              rst,
  totp_host_driver_if.master bus
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_SEND_KEY   = 3'd1;
  localparam logic [2:0] S_GAP        = 3'd2;
  localparam logic [2:0] S_SEND_MSG   = 3'd3;
  localparam logic [2:0] S_WAIT_READY = 3'd4;
  localparam logic [2:0] S_SELECT     = 3'd5;
  localparam logic [2:0] S_DONE       = 3'd6;

  localparam int BW = $clog2(((KEY_BITS > MSG_BITS) ? KEY_BITS : MSG_BITS) + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int CW = 4 * DIGITS;

  logic [2:0]          state_q, state_d;
  logic [KEY_BITS-1:0] key_q, key_d;
  logic [MSG_BITS-1:0] msg_q, msg_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [WW-1:0]       wait_q, wait_d;
  logic [SW-1:0]       settle_q, settle_d;
  logic [CW-1:0]       shadow_q, shadow_d;
  logic                bad_q, bad_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [CW-1:0]       code_q, code_d;
  logic                data_q, data_d;
  logic                key_en_q, key_en_d;
  logic                msg_en_q, msg_en_d;
  logic [2:0]          sel_q, sel_d;

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    msg_d    = msg_q;
    bit_d    = bit_q;
    wait_d   = wait_q;
    settle_d = settle_q;
    shadow_d = shadow_q;
    bad_d    = bad_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = error_q;
    code_d   = code_q;
    data_d   = data_q;
    key_en_d = key_en_q;
    msg_en_d = msg_en_q;
    sel_d    = sel_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          key_d   = bus.key;
          msg_d   = bus.msg;
          error_d = 1'b0;
          busy_d  = 1'b1;
          bit_d   = '0;
          bad_d   = 1'b0;
          state_d = S_SEND_KEY;
        end
      end

      // The latched copy is shifted left so the MSB is always the next bit.
      S_SEND_KEY: begin
        data_d   = key_q[KEY_BITS-1];
        key_en_d = 1'b1;
        msg_en_d = 1'b0;
        key_d    = {key_q[KEY_BITS-2:0], 1'b0};
        if (bit_q == BW'(KEY_BITS - 1)) begin
          bit_d   = '0;
          state_d = S_GAP;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end

      S_GAP: begin
        data_d   = 1'b0;
        key_en_d = 1'b0;
        msg_en_d = 1'b0;
        state_d  = S_SEND_MSG;
      end

      S_SEND_MSG: begin
        data_d   = msg_q[MSG_BITS-1];
        key_en_d = 1'b0;
        msg_en_d = 1'b1;
        msg_d    = {msg_q[MSG_BITS-2:0], 1'b0};
        if (bit_q == BW'(MSG_BITS - 1)) begin
          bit_d   = '0;
          wait_d  = '0;
          state_d = S_WAIT_READY;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end

      // Ready wins over the timeout on the final allowed sample.
      S_WAIT_READY: begin
        data_d   = 1'b0;
        key_en_d = 1'b0;
        msg_en_d = 1'b0;
        if (bus.ready) begin
          sel_d    = 3'd0;
          settle_d = '0;
          state_d  = S_SELECT;
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end

      // Each digit holds sel for SETTLE cycles and samples on the next edge.
      // An out-of-range digit is remembered and reported alongside done so
      // busy and error never disagree mid-transaction.
      S_SELECT: begin
        if (settle_q == SW'(SETTLE)) begin
          for (int i = 0; i < DIGITS; i++) begin
            if (sel_q == 3'(i)) begin
              shadow_d[4*i +: 4] = bus.bcd;
            end
          end
          if (bus.bcd > 4'd9) begin
            bad_d = 1'b1;
          end
          settle_d = '0;
          if (sel_q == 3'(DIGITS - 1)) begin
            state_d = S_DONE;
          end else begin
            sel_d = sel_q + 3'd1;
          end
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end

      S_DONE: begin
        code_d  = shadow_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        error_d = error_q | bad_q;
        sel_d   = 3'd0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      key_q    <= '0;
      msg_q    <= '0;
      bit_q    <= '0;
      wait_q   <= '0;
      settle_q <= '0;
      shadow_q <= '0;
      bad_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      code_q   <= '0;
      data_q   <= 1'b0;
      key_en_q <= 1'b0;
      msg_en_q <= 1'b0;
      sel_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      msg_q    <= msg_d;
      bit_q    <= bit_d;
      wait_q   <= wait_d;
      settle_q <= settle_d;
      shadow_q <= shadow_d;
      bad_q    <= bad_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      code_q   <= code_d;
      data_q   <= data_d;
      key_en_q <= key_en_d;
      msg_en_q <= msg_en_d;
      sel_q    <= sel_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.error  = error_q;
  assign bus.code   = code_q;
  assign bus.data   = data_q;
  assign bus.key_en = key_en_q;
  assign bus.msg_en = msg_en_q;
  assign bus.sel    = sel_q;

endmodule

// File: tb/tb_totp_host_driver.sv
// Bench for totp_host_driver with a behavioural TOTP core model.
// Stimulus pushes expected results into a queue; a negedge monitor pops and
// compares whenever busy falls (done or timeout).
module tb_totp_host_driver;
  localparam int KB = 160;
  localparam int MB = 64;
  localparam int DG = 6;
  localparam int ST = 2;
  localparam int TO = 20;

  localparam logic [KB-1:0] KEY_A = 160'h3132333435363738393031323334353637383930;
  localparam logic [KB-1:0] KEY_B = 160'h0123456789ABCDEF0011223344556677DEADBEEF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  totp_host_driver_if #(.KEY_BITS(KB), .MSG_BITS(MB), .DIGITS(DG)) bus ();

  totp_host_driver #(
    .KEY_BITS(KB), .MSG_BITS(MB), .DIGITS(DG), .SETTLE(ST), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- core model ----------------
  int          lat_cfg = 0;      // <0 never ready, 0 ready held high, >0 delay
  logic        pulse_cfg = 1'b0; // ready high for one cycle only
  logic [3:0]  tab [8];          // digit returned per sel value
  logic [KB-1:0] kshift = '0;
  logic [MB-1:0] mshift = '0;
  int kcnt = 0, mcnt = 0, rcnt = 0, gapcnt = 0;
  logic rst_q = 1'b0;

  always @(posedge clk) begin
    rst_q <= rst;
    if (!bus.busy) begin
      kcnt <= 0; mcnt <= 0; rcnt <= 0; gapcnt <= 0;
    end else begin
      if (bus.key_en) begin
        kshift <= {kshift[KB-2:0], bus.data};
        kcnt   <= kcnt + 1;
      end
      if (bus.msg_en) begin
        mshift <= {mshift[MB-2:0], bus.data};
        mcnt   <= mcnt + 1;
      end
      if (bus.msg_en && mcnt == MB - 1) rcnt <= 1;
      else if (rcnt != 0)               rcnt <= rcnt + 1;
      if (kcnt == KB && mcnt == 0 && !bus.key_en && !bus.msg_en) gapcnt <= gapcnt + 1;
    end
  end

  always_comb begin
    bus.ready = 1'b0;
    if (lat_cfg == 0)     bus.ready = 1'b1;
    else if (lat_cfg > 0) bus.ready = pulse_cfg ? (rcnt == lat_cfg) : (rcnt >= lat_cfg);
    bus.bcd = tab[bus.sel];
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        done;
    logic        err;
    logic [23:0] code;
    int          lat;
    logic [KB-1:0] key;
    logic [MB-1:0] msg;
  } exp_t;
  exp_t sbq[$];
  int   exp_dones = 0;

  int   done_seen = 0;
  logic both_en = 1'b0;
  logic data_bad = 1'b0;

  initial begin : monitor
    logic busy_prev;
    int   t;
    exp_t e;
    busy_prev = 1'b0;
    t = 0;
    forever begin
      @(negedge clk);
      if (bus.key_en && bus.msg_en) both_en = 1'b1;
      if (!bus.key_en && !bus.msg_en && bus.data === 1'b1) data_bad = 1'b1;
      if (bus.done === 1'b1) done_seen++;
      if (bus.busy && !busy_prev) t = 0;
      else t++;
      if (!bus.busy && busy_prev && !rst_q) begin
        if (sbq.size() == 0) begin
          chk("unexpected_completion", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("done",      bus.done,  e.done);
          chk("error",     bus.error, e.err);
          chk("code",      bus.code,  e.code);
          chk("latency",   t,         e.lat);
          chk("key_bits",  kshift,    e.key);
          chk("msg_bits",  mshift,    e.msg);
          chk("key_count", kcnt,      KB);
          chk("msg_count", mcnt,      MB);
          chk("gap_len",   gapcnt,    1);
          chk("sel_home",  bus.sel,   0);
        end
      end
      busy_prev = bus.busy;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_core(input int lat, input logic pls, input logic [23:0] digs);
    lat_cfg   = lat;
    pulse_cfg = pls;
    for (int i = 0; i < DG; i++) tab[i] = digs[4*i +: 4];
  endtask

  task automatic push(input logic d, input logic er, input logic [23:0] c, input int l,
                      input logic [KB-1:0] k, input logic [MB-1:0] m);
    exp_t e;
    e.done = d; e.err = er; e.code = c; e.lat = l; e.key = k; e.msg = m;
    sbq.push_back(e);
    if (d) exp_dones++;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", bus.busy, 0);
  endtask

  task automatic txn(input logic [KB-1:0] k, input logic [MB-1:0] m, input int lat,
                     input logic pls, input logic [23:0] digs, input logic e_done,
                     input logic e_err, input logic [23:0] e_code, input int e_lat);
    @(negedge clk);
    set_core(lat, pls, digs);
    bus.key = k;
    bus.msg = m;
    push(e_done, e_err, e_code, e_lat, k, m);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    chk("error_cleared", bus.error, 0);
    wait_idle();
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  // Base latency with ready seen on the first wait cycle:
  // 160 + 64 + 2 + 6*(2+1) + 1 = 245 edges after the accepting edge.
  initial begin : stim
    int n;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.key = '0;
    bus.msg = '0;
    set_core(0, 1'b0, 24'h0);
    tab[6] = 4'h0;
    tab[7] = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.busy, bus.done, bus.error, bus.code, bus.data,
                          bus.key_en, bus.msg_en, bus.sel}, 0);
    @(negedge clk);
    rst = 1'b0;

    // RFC vector, ready two cycles into the wait
    txn(KEY_A, 64'd1, 2, 1'b0, 24'h287082, 1'b1, 1'b0, 24'h287082, 247);
    // ready already high when the wait begins
    txn(KEY_A, 64'd1, 0, 1'b0, 24'h287082, 1'b1, 1'b0, 24'h287082, 245);
    // other key/message, single-cycle ready pulse
    txn(KEY_B, 64'h0123456789ABCDEF, 5, 1'b1, 24'h431509, 1'b1, 1'b0, 24'h431509, 250);
    // ready never comes: error after 20 wait cycles, code retained
    txn(KEY_A, 64'd1, -1, 1'b0, 24'h287082, 1'b0, 1'b1, 24'h431509, 245);
    // out-of-range digit at sel=3 (previous error cleared by this start)
    txn(KEY_A, 64'd1, 1, 1'b0, 24'h28B082, 1'b1, 1'b1, 24'h28B082, 246);

    // reset in the middle of the message
    @(negedge clk);
    set_core(2, 1'b0, 24'h287082);
    bus.key = KEY_A;
    bus.msg = 64'd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (180) @(negedge clk);
    chk("in_send_msg", bus.msg_en, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrun_reset_outputs", {bus.busy, bus.done, bus.error, bus.code, bus.data,
                                 bus.key_en, bus.msg_en, bus.sel}, 0);
    @(negedge clk);
    rst = 1'b0;
    txn(KEY_A, 64'd1, 2, 1'b0, 24'h287082, 1'b1, 1'b0, 24'h287082, 247);

    // start pulses during SEND_KEY and WAIT_READY are ignored
    @(negedge clk);
    set_core(8, 1'b0, 24'h287082);
    bus.key = KEY_A;
    bus.msg = 64'd1;
    push(1'b1, 1'b0, 24'h287082, 253, KEY_A, 64'd1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (50) @(negedge clk);
    bus.key = KEY_B;
    bus.msg = 64'hFFFF_0000_FFFF_0000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (177) @(negedge clk);
    chk("in_wait_ready", {bus.busy, bus.key_en, bus.msg_en}, 3'b100);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    chk("no_restart", bus.busy, 0);

    // start held high: two back-to-back transactions
    @(negedge clk);
    set_core(0, 1'b0, 24'h287082);
    bus.key = KEY_B;
    bus.msg = 64'd2;
    push(1'b1, 1'b0, 24'h287082, 245, KEY_B, 64'd2);
    push(1'b1, 1'b0, 24'h287082, 245, KEY_B, 64'd2);
    bus.start = 1'b1;
    @(negedge clk);
    wait_idle();
    n = 0;
    while (!bus.busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_restart", bus.busy, 1);
    bus.start = 1'b0;
    wait_idle();

    repeat (5) @(negedge clk);
    chk("done_pulse_count", done_seen, exp_dones);
    chk("scoreboard_drained", sbq.size(), 0);
    chk("enables_exclusive", both_en, 0);
    chk("data_low_when_idle", data_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/totp_host_driver.md
Name: totp_host_driver

Overview:
- Host-side initiator for the TOTP core's serial load/readout interface; sits on the host or test-harness side, facing the chip pins.
- Serializes a latched key, then a latched counter message, onto data/key_en/msg_en.
- Waits for the core's ready, then steps sel through every digit position, samples bcd and returns the assembled code as parallel BCD.

Parameters:
- KEY_BITS, 160, key length in bits (SHA-1 block key).
- MSG_BITS, 64, message (time-step counter) length in bits.
- DIGITS, 6, digit positions read back; must be 1..8.
- SETTLE, 2, cycles sel is held before bcd is sampled; must be >= 1.
- TIMEOUT, 65535, maximum cycles to wait for ready.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request a transaction; honoured only when busy=0
- key  in  KEY_BITS  key, latched on the accepted start
- msg  in  MSG_BITS  message, latched on the accepted start
- busy  out  1  high from the cycle after an accepted start until the cycle done/error asserts
- done  out  1  one-cycle pulse when code is valid
- error  out  1  sticky; cleared by the next accepted start or by rst
- code  out  4*DIGITS  digit for sel=i in code[4*i+3:4*i]; held until the next completion
- data  out  1  serial bit to core
- key_en  out  1  key bit qualifier
- msg_en  out  1  message bit qualifier
- sel  out  3  digit select to core
- ready  in  1  core result-valid
- bcd  in  4  digit returned by core for the current sel

Behaviour:
- Reset, synchronous, highest priority, effective from any state mid-operation:
  - outputs: busy=0, done=0, error=0, code=0, data=0, key_en=0, msg_en=0, sel=0.
  - state goes to IDLE and all counters clear.
- All outputs are registered.
- States and transitions:
  - IDLE: start=1 latches key and msg, clears error and goes to SEND_KEY. Start in any other state is ignored.
  - SEND_KEY: KEY_BITS cycles with key_en=1, msg_en=0, data=key MSB first (bit KEY_BITS-1 in the first cycle). Then GAP.
  - GAP: exactly 1 cycle with key_en=0, msg_en=0, data=0. Then SEND_MSG.
  - SEND_MSG: MSG_BITS cycles with msg_en=1, key_en=0, data=msg MSB first. Then WAIT_READY.
  - WAIT_READY:
    - enables low, data=0.
    - ready sampled 1 goes to SELECT with sel=0.
    - if the wait counter reaches TIMEOUT without ready: error=1, busy=0, no done, return to IDLE; code unchanged.
    - ready already high on entry is accepted on the first WAIT_READY cycle.
  - SELECT:
    - drive sel=i for SETTLE cycles, then sample bcd into a shadow register slot i.
    - bcd>9 sets error=1; the value is still stored and the transaction continues.
    - i increments; after i=DIGITS-1, go to DONE.
    - ready deasserting during SELECT is ignored.
  - DONE: copy shadow to code; done=1 for one cycle; busy=0; sel returns to 0; back to IDLE.
- Exactly one of key_en/msg_en, or neither, is ever high; both high is illegal and is never driven.
- Cycle count, start accepted at edge 0:
  - first key bit at edge 1.
  - GAP at edge KEY_BITS+1.
  - first msg bit at edge KEY_BITS+2.
  - WAIT_READY from edge KEY_BITS+MSG_BITS+2.
  - done = (ready latency) + DIGITS*(SETTLE+1) + 1 cycles after WAIT_READY exits.
- A new start is accepted in the same cycle done is high only if busy=0, i.e. from IDLE the following cycle. start held high causes back-to-back transactions.

Test Plan:
- Defaults, key=0x3132...30 (ASCII "12345678901234567890"), msg=1, behavioural core model returns 287082: data/key_en/msg_en sequence matches bit-for-bit, with a 1-cycle gap; code=0x287082 in sel order; done pulses once; error=0.
- ready already high on entering WAIT_READY: SELECT begins the next cycle; total latency is minimal per the cycle count.
- ready never asserts, TIMEOUT=20: error=1 exactly 20 cycles into WAIT_READY; no done; busy=0; previous code retained; the next start clears error.
- Core model returns bcd=0xB at sel=3: code digit 3 = 0xB, error=1 and done=1 in the same cycle.
- rst pulsed mid-SEND_MSG: the next cycle has all outputs 0 and state IDLE; a fresh start then completes normally.
- start pulsed during SEND_KEY and WAIT_READY: ignored; latched key/msg unchanged; exactly one done.
